// File: rtl/csr_file.sv
// csr_file: LoongArch architectural control/status registers.
// Serves combinational CSR reads for the write-back stage, commits masked
// software writes, records exception / ertn state, and owns the stable
// counter, the countdown timer and the interrupt request back to decode.
module csr_file #(
  parameter int TIMER_W = 32,
  parameter int HWI_N   = 8
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               csr_re,
  input  logic [13:0]        csr_num,
  output logic [31:0]        csr_rvalue,
  input  logic               csr_we,
  input  logic [31:0]        csr_wmask,
  input  logic [31:0]        csr_wvalue,
  input  logic               wb_ex,
  input  logic [5:0]         wb_ecode,
  input  logic [8:0]         wb_esubcode,
  input  logic [31:0]        wb_ex_pc,
  input  logic [31:0]        wb_badv,
  input  logic               ertn_flush,
  input  logic [HWI_N-1:0]   hw_int_in,
  input  logic               ipi_int_in,
  output logic               has_int,
  output logic [63:0]        counter_value
);

  // CSR addresses decoded by this block
  localparam logic [13:0] CSR_CRMD      = 14'h0000;
  localparam logic [13:0] CSR_PRMD      = 14'h0001;
  localparam logic [13:0] CSR_ECFG      = 14'h0004;
  localparam logic [13:0] CSR_ESTAT     = 14'h0005;
  localparam logic [13:0] CSR_ERA       = 14'h0006;
  localparam logic [13:0] CSR_BADV      = 14'h0007;
  localparam logic [13:0] CSR_EENTRY    = 14'h000c;
  localparam logic [13:0] CSR_SAVE0     = 14'h0030;
  localparam logic [13:0] CSR_SAVE1     = 14'h0031;
  localparam logic [13:0] CSR_SAVE2     = 14'h0032;
  localparam logic [13:0] CSR_SAVE3     = 14'h0033;
  localparam logic [13:0] CSR_TID       = 14'h0040;
  localparam logic [13:0] CSR_TCFG      = 14'h0041;
  localparam logic [13:0] CSR_TVAL      = 14'h0042;
  localparam logic [13:0] CSR_TICLR     = 14'h0044;
  localparam logic [13:0] CSR_TLBRENTRY = 14'h0088;

  // Software-writable bits of each register
  localparam logic [31:0] WM_CRMD  = 32'h0000_01ff;
  localparam logic [31:0] WM_PRMD  = 32'h0000_0007;
  localparam logic [31:0] WM_ECFG  = 32'h0000_1bff;
  localparam logic [31:0] WM_ESTAT = 32'h0000_0003;
  localparam logic [31:0] WM_FULL  = 32'hffff_ffff;
  localparam logic [31:0] WM_ENTRY = 32'hffff_ffc0;
  localparam logic [31:0] WM_NONE  = 32'h0000_0000;

  // TLB refill exception code: switches translation mode on entry/return
  localparam logic [5:0] ECODE_TLBR = 6'h3f;

  localparam logic [TIMER_W-1:0] TVAL_ZERO = TIMER_W'(32'd0);
  localparam logic [TIMER_W-1:0] TVAL_ONE  = TIMER_W'(32'd1);

  // Masked update restricted to the register's writable bits
  function automatic logic [31:0] masked_write(input logic [31:0] old_v,
                                               input logic [31:0] wv,
                                               input logic [31:0] wm,
                                               input logic [31:0] wr_bits);
    logic [31:0] eff;
    eff = wm & wr_bits;
    return (old_v & ~eff) | (wv & eff);
  endfunction

  // Exception codes that carry a faulting virtual address
  function automatic logic ecode_sets_badv(input logic [5:0] ec);
    case (ec)
      6'h01, 6'h02, 6'h03, 6'h04, 6'h07, 6'h08, 6'h09, 6'h3f: return 1'b1;
      default: return 1'b0;
    endcase
  endfunction

  // Architectural state
  logic [8:0]         crmd_q, crmd_d;
  logic [2:0]         prmd_q, prmd_d;
  logic [12:0]        lie_q, lie_d;
  logic [1:0]         is_sw_q, is_sw_d;
  logic [HWI_N-1:0]   hwi_q;
  logic               ipi_q;
  logic               ti_q, ti_d;
  logic [5:0]         ecode_q, ecode_d;
  logic [8:0]         esub_q, esub_d;
  logic [31:0]        era_q, era_d;
  logic [31:0]        badv_q, badv_d;
  logic [25:0]        eentry_q, eentry_d;
  logic [25:0]        tlbrentry_q, tlbrentry_d;
  logic [3:0][31:0]   save_q, save_d;
  logic [31:0]        tid_q, tid_d;
  logic [31:0]        tcfg_q, tcfg_d;
  logic [TIMER_W-1:0] tval_q, tval_d;
  logic [63:0]        cnt_q;

  // Full 32-bit read views of each register
  logic [7:0]  hwi8_s;
  logic [31:0] crmd_v_s, prmd_v_s, ecfg_v_s, estat_v_s;
  logic [31:0] eentry_v_s, tlbrentry_v_s, tval_v_s;
  logic [31:0] rdata_s, wr_bits_s, wdata_s;
  logic        sw_we_s, tcfg_load_s, ticlr_s, ti_fire_s;
  logic [TIMER_W-1:0] reload_cur_s, reload_new_s;
  logic        unused_s;

  assign unused_s      = csr_re;
  assign hwi8_s        = 8'(hwi_q);
  assign crmd_v_s      = {23'd0, crmd_q};
  assign prmd_v_s      = {29'd0, prmd_q};
  assign ecfg_v_s      = {19'd0, lie_q};
  assign estat_v_s     = {1'b0, esub_q, ecode_q, 3'b000, ipi_q, ti_q, 1'b0, hwi8_s, is_sw_q};
  assign eentry_v_s    = {eentry_q, 6'd0};
  assign tlbrentry_v_s = {tlbrentry_q, 6'd0};
  assign tval_v_s      = 32'(tval_q);

  // Read mux: combinational from current state; unmapped addresses read 0
  always_comb begin
    rdata_s = 32'd0;
    case (csr_num)
      CSR_CRMD:      rdata_s = crmd_v_s;
      CSR_PRMD:      rdata_s = prmd_v_s;
      CSR_ECFG:      rdata_s = ecfg_v_s;
      CSR_ESTAT:     rdata_s = estat_v_s;
      CSR_ERA:       rdata_s = era_q;
      CSR_BADV:      rdata_s = badv_q;
      CSR_EENTRY:    rdata_s = eentry_v_s;
      CSR_SAVE0:     rdata_s = save_q[0];
      CSR_SAVE1:     rdata_s = save_q[1];
      CSR_SAVE2:     rdata_s = save_q[2];
      CSR_SAVE3:     rdata_s = save_q[3];
      CSR_TID:       rdata_s = tid_q;
      CSR_TCFG:      rdata_s = tcfg_q;
      CSR_TVAL:      rdata_s = tval_v_s;
      CSR_TICLR:     rdata_s = 32'd0;
      CSR_TLBRENTRY: rdata_s = tlbrentry_v_s;
      default:       rdata_s = 32'd0;
    endcase
  end

  assign csr_rvalue = rdata_s;

  // Writable-bit mask for the addressed register (0 for read-only/unmapped)
  always_comb begin
    wr_bits_s = WM_NONE;
    case (csr_num)
      CSR_CRMD:      wr_bits_s = WM_CRMD;
      CSR_PRMD:      wr_bits_s = WM_PRMD;
      CSR_ECFG:      wr_bits_s = WM_ECFG;
      CSR_ESTAT:     wr_bits_s = WM_ESTAT;
      CSR_ERA, CSR_BADV, CSR_SAVE0, CSR_SAVE1, CSR_SAVE2, CSR_SAVE3,
      CSR_TID, CSR_TCFG: wr_bits_s = WM_FULL;
      CSR_EENTRY, CSR_TLBRENTRY: wr_bits_s = WM_ENTRY;
      default:       wr_bits_s = WM_NONE;
    endcase
  end

  // Exception and ertn commits both suppress the same-cycle software write
  assign sw_we_s      = csr_we & ~wb_ex & ~ertn_flush;
  assign wdata_s      = masked_write(rdata_s, csr_wvalue, csr_wmask, wr_bits_s);
  assign tcfg_load_s  = sw_we_s && (csr_num == CSR_TCFG) && wdata_s[0];
  assign ticlr_s      = sw_we_s && (csr_num == CSR_TICLR) && csr_wvalue[0] && csr_wmask[0];
  assign ti_fire_s    = tcfg_q[0] && (tval_q == TVAL_ONE);
  assign reload_cur_s = TIMER_W'({tcfg_q[31:2], 2'b00});
  assign reload_new_s = TIMER_W'({wdata_s[31:2], 2'b00});

  // Exception-state registers: exception entry, ertn, else software write
  always_comb begin
    crmd_d  = crmd_q;
    prmd_d  = prmd_q;
    era_d   = era_q;
    badv_d  = badv_q;
    ecode_d = ecode_q;
    esub_d  = esub_q;
    if (wb_ex) begin
      // {PIE,PPLV} <= {IE,PLV}; drop to kernel with interrupts off
      prmd_d      = crmd_q[2:0];
      crmd_d[2:0] = 3'b000;
      if (wb_ecode == ECODE_TLBR) begin
        crmd_d[4:3] = 2'b01;
      end else begin
        crmd_d[4:3] = crmd_q[4:3];
      end
      era_d   = wb_ex_pc;
      ecode_d = wb_ecode;
      esub_d  = wb_esubcode;
      if (ecode_sets_badv(wb_ecode)) begin
        badv_d = wb_badv;
      end else begin
        badv_d = badv_q;
      end
    end else if (ertn_flush) begin
      crmd_d[2:0] = prmd_q;
      if (ecode_q == ECODE_TLBR) begin
        crmd_d[4:3] = 2'b10;
      end else begin
        crmd_d[4:3] = crmd_q[4:3];
      end
    end else if (sw_we_s) begin
      case (csr_num)
        CSR_CRMD: crmd_d = wdata_s[8:0];
        CSR_PRMD: prmd_d = wdata_s[2:0];
        CSR_ERA:  era_d  = wdata_s;
        CSR_BADV: badv_d = wdata_s;
        default:  crmd_d = crmd_q;
      endcase
    end else begin
      crmd_d = crmd_q;
    end
  end

  // Plain software-owned registers
  always_comb begin
    lie_d       = lie_q;
    is_sw_d     = is_sw_q;
    eentry_d    = eentry_q;
    tlbrentry_d = tlbrentry_q;
    save_d      = save_q;
    tid_d       = tid_q;
    tcfg_d      = tcfg_q;
    if (sw_we_s) begin
      case (csr_num)
        CSR_ECFG:      lie_d       = wdata_s[12:0];
        CSR_ESTAT:     is_sw_d     = wdata_s[1:0];
        CSR_EENTRY:    eentry_d    = wdata_s[31:6];
        CSR_TLBRENTRY: tlbrentry_d = wdata_s[31:6];
        CSR_SAVE0:     save_d[0]   = wdata_s;
        CSR_SAVE1:     save_d[1]   = wdata_s;
        CSR_SAVE2:     save_d[2]   = wdata_s;
        CSR_SAVE3:     save_d[3]   = wdata_s;
        CSR_TID:       tid_d       = wdata_s;
        CSR_TCFG:      tcfg_d      = wdata_s;
        default:       tid_d       = tid_q;
      endcase
    end else begin
      tid_d = tid_q;
    end
  end

  // Countdown timer and its interrupt flag; a firing always beats a clear
  always_comb begin
    tval_d = tval_q;
    ti_d   = ti_q;
    if (tcfg_load_s) begin
      tval_d = reload_new_s;
    end else if (ti_fire_s) begin
      tval_d = tcfg_q[1] ? reload_cur_s : TVAL_ZERO;
    end else if (tcfg_q[0] && (tval_q != TVAL_ZERO)) begin
      tval_d = tval_q - TVAL_ONE;
    end else begin
      tval_d = tval_q;
    end
    if (ti_fire_s) begin
      ti_d = 1'b1;
    end else if (ticlr_s) begin
      ti_d = 1'b0;
    end else begin
      ti_d = ti_q;
    end
  end

  // State registers, cleared asynchronously; CRMD comes up in direct-address mode
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      crmd_q      <= 9'h008;
      prmd_q      <= 3'd0;
      lie_q       <= 13'd0;
      is_sw_q     <= 2'd0;
      hwi_q       <= {HWI_N{1'b0}};
      ipi_q       <= 1'b0;
      ti_q        <= 1'b0;
      ecode_q     <= 6'd0;
      esub_q      <= 9'd0;
      era_q       <= 32'd0;
      badv_q      <= 32'd0;
      eentry_q    <= 26'd0;
      tlbrentry_q <= 26'd0;
      save_q      <= {4{32'd0}};
      tid_q       <= 32'd0;
      tcfg_q      <= 32'd0;
      tval_q      <= TVAL_ZERO;
      cnt_q       <= 64'd0;
    end else begin
      crmd_q      <= crmd_d;
      prmd_q      <= prmd_d;
      lie_q       <= lie_d;
      is_sw_q     <= is_sw_d;
      hwi_q       <= hw_int_in;
      ipi_q       <= ipi_int_in;
      ti_q        <= ti_d;
      ecode_q     <= ecode_d;
      esub_q      <= esub_d;
      era_q       <= era_d;
      badv_q      <= badv_d;
      eentry_q    <= eentry_d;
      tlbrentry_q <= tlbrentry_d;
      save_q      <= save_d;
      tid_q       <= tid_d;
      tcfg_q      <= tcfg_d;
      tval_q      <= tval_d;
      cnt_q       <= cnt_q + 64'd1;
    end
  end

  assign has_int       = crmd_q[2] & (|(estat_v_s[12:0] & lie_q));
  assign counter_value = cnt_q;

endmodule
